sub_serial_unit: RTL

Multi-cycle bit-serial subtractor for the ALU datapath, the inverse operation to the 2-bit adder. Computes A − B one bit per clock with a ripple borrow held in a flop, using a start/busy/done handshake. The result layout matches the adder output: difference in the low bits, then borrow, then zero padding. The ALU result mux selects this output for the SUB opcode.

---
 rtl/sub_serial_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/sub_serial_unit.sv
// Bit-serial subtractor: computes A - B one bit per clock with a registered ripple borrow.
// Result layout mirrors the adder: difference low, borrow above it, zero padding on top.
module sub_serial_unit #(
   parameter int WIDTH     = 2,
   parameter int OUT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [OUT_WIDTH-1:0] SUB_Out,
   output logic [1:0]           dbg_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       a_q, a_d;
   logic [WIDTH-1:0]       b_q, b_d;
   logic [WIDTH-1:0]       diff_q, diff_d;
   logic                   br_q, br_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0]   sub_out_q, sub_out_d;

   logic                   bit_d;
   logic                   br_nxt;
   logic [WIDTH:0]         shift_full;
   logic [WIDTH-1:0]       diff_shift;
   logic [OUT_WIDTH-1:0]   result;

   // Full-subtractor cell on the operand LSBs; the new bit enters at the MSB so
   // that after WIDTH shifts bit i sits at position i.
   always_comb begin
      bit_d      = a_q[0] ^ b_q[0] ^ br_q;
      br_nxt     = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
      shift_full = {bit_d, diff_q};
      diff_shift = shift_full[WIDTH:1];
      result     = '0;
      result[WIDTH:0] = {br_nxt, diff_shift};
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      diff_d    = diff_q;
      br_d      = br_q;
      cnt_d     = cnt_q;
      sub_out_d = sub_out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               diff_d  = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            diff_d = diff_shift;
            br_d   = br_nxt;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               sub_out_d = result;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            // Start is deliberately not looked at here, so it cannot be queued.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         diff_q    <= '0;
         br_q      <= 1'b0;
         cnt_q     <= '0;
         sub_out_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         diff_q    <= diff_d;
         br_q      <= br_d;
         cnt_q     <= cnt_d;
         sub_out_q <= sub_out_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign SUB_Out   = sub_out_q;
   assign dbg_state = state_q;

endmodule
